// File: rtl/game_pkg.sv
// Shared definitions for the game-flow controller: state encoding,
// default scoring constant and a popcount helper for hit vectors.
package game_pkg;

    typedef enum logic [1:0] {
        ST_HOME  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_END   = 2'd3
    } state_e;

    localparam int DEFAULT_ENEMY_POINTS = 10;

    // Number of set bits in a hit vector (vectors up to 32 enemies wide).
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: counts clk cycles while running and emits a
// registered one-cycle tick each time the count wraps FRAME_DIV-1 -> 0.
module frame_tick_gen #(
    parameter int FRAME_DIV = 833_333
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(FRAME_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Next count: clear wins, otherwise advance only while running, else hold.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            if (cnt_q == CNT_W'(FRAME_DIV - 1)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter and tick registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: HOME/PLAY/PAUSE/END sequencing, frame ticks,
// kill scoring with saturation, health with post-hit invulnerability,
// persistent high score and per-enemy respawn pulses. All outputs are
// registered; the state output doubles as the FSM debug view.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int NUM_ENEMIES   = 3,
    parameter int SCORE_W       = 16,
    parameter int HEALTH_MAX    = 3,
    parameter int ENEMY_POINTS  = DEFAULT_ENEMY_POINTS,
    parameter int FRAME_DIV     = 833_333,
    parameter int INVULN_FRAMES = 60,
    localparam int HEALTH_W     = $clog2(HEALTH_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   pause,
    input  logic [NUM_ENEMIES-1:0] enemy_hit,
    input  logic [NUM_ENEMIES-1:0] player_hit,
    output logic [1:0]             state,
    output logic                   playing,
    output logic                   game_end,
    output logic                   frame_tick,
    output logic [SCORE_W-1:0]     score,
    output logic [SCORE_W-1:0]     high_score,
    output logic [HEALTH_W-1:0]    health,
    output logic                   invuln,
    output logic [NUM_ENEMIES-1:0] enemy_respawn
);

    localparam int INV_W = (INVULN_FRAMES < 1) ? 1 : $clog2(INVULN_FRAMES + 1);
    localparam int SUM_W = SCORE_W + 32;
    localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});

    state_e                 state_q, state_d;
    logic                   start_q, pause_q;
    logic                   playing_q, end_q;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [SCORE_W-1:0]     high_q, high_d;
    logic [HEALTH_W-1:0]    health_q, health_d;
    logic [INV_W-1:0]       inv_q, inv_d;
    logic [NUM_ENEMIES-1:0] respawn_q, respawn_d;

    logic                   start_rise, pause_rise;
    logic [NUM_ENEMIES-1:0] eff_hit;
    logic [SUM_W-1:0]       score_sum;
    logic [SCORE_W-1:0]     score_kill;
    logic                   frame_run, frame_clear;

    // Rising edges of the button levels; a kill on the same index cancels damage.
    always_comb begin
        start_rise = start & ~start_q;
        pause_rise = pause & ~pause_q;
        eff_hit    = player_hit & ~enemy_hit;
        score_sum  = SUM_W'(score_q)
                   + SUM_W'(ENEMY_POINTS) * SUM_W'(popcount(32'(enemy_hit)));
        score_kill = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    end

    // Next-state and datapath update for the game flow.
    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        high_d    = high_q;
        health_d  = health_q;
        inv_d     = inv_q;
        respawn_d = '0;
        case (state_q)
            ST_HOME: begin
                if (start_rise) begin
                    state_d   = ST_PLAY;
                    health_d  = HEALTH_W'(HEALTH_MAX);
                    score_d   = '0;
                    inv_d     = '0;
                    respawn_d = '1;
                end
            end
            ST_PLAY: begin
                score_d   = score_kill;
                respawn_d = enemy_hit | eff_hit;
                if (pause_rise) begin
                    state_d = ST_PAUSE;
                end
                if (frame_tick && inv_q != '0) begin
                    inv_d = inv_q - INV_W'(1);
                end
                if (eff_hit != '0 && inv_q == '0) begin
                    health_d = health_q - HEALTH_W'(1);
                    inv_d    = INV_W'(INVULN_FRAMES);
                    // Death overrides a simultaneous pause request.
                    if (health_q == HEALTH_W'(1)) begin
                        state_d = ST_END;
                        high_d  = (score_kill > high_q) ? score_kill : high_q;
                    end
                end
            end
            ST_PAUSE: begin
                if (pause_rise) begin
                    state_d = ST_PLAY;
                end
            end
            ST_END: begin
                if (start_rise) begin
                    state_d = ST_HOME;
                end
            end
            default: state_d = ST_HOME;
        endcase
    end

    // The frame counter only advances across edges that stay in PLAY, so the
    // edge that enters PAUSE neither advances it nor lets a tick leak into PAUSE.
    always_comb begin
        frame_run   = (state_q == ST_PLAY) && (state_d == ST_PLAY);
        frame_clear = (state_q == ST_HOME) && start_rise;
    end

    frame_tick_gen #(
        .FRAME_DIV(FRAME_DIV)
    ) u_frame_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .run  (frame_run),
        .clear(frame_clear),
        .tick (frame_tick)
    );

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_HOME;
            start_q   <= 1'b0;
            pause_q   <= 1'b0;
            playing_q <= 1'b0;
            end_q     <= 1'b0;
            score_q   <= '0;
            high_q    <= '0;
            health_q  <= '0;
            inv_q     <= '0;
            respawn_q <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start;
            pause_q   <= pause;
            playing_q <= (state_d == ST_PLAY);
            end_q     <= (state_d == ST_END);
            score_q   <= score_d;
            high_q    <= high_d;
            health_q  <= health_d;
            inv_q     <= inv_d;
            respawn_q <= respawn_d;
        end
    end

    assign state         = state_q;
    assign playing       = playing_q;
    assign game_end      = end_q;
    assign score         = score_q;
    assign high_score    = high_q;
    assign health        = health_q;
    assign invuln        = (inv_q != '0);
    assign enemy_respawn = respawn_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the game rules.
module tb_game_flow_ctrl;

    localparam int NE  = 3;
    localparam int SW  = 8;
    localparam int HM  = 3;
    localparam int PTS = 10;
    localparam int FD  = 4;
    localparam int INV = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic [NE-1:0] enemy_hit = '0;
    logic [NE-1:0] player_hit = '0;
    logic [1:0]    state;
    logic          playing, game_end, frame_tick, invuln;
    logic [SW-1:0] score, high_score;
    logic [1:0]    health;
    logic [NE-1:0] enemy_respawn;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the game rules (values after the latest edge).
    int            m_state, m_score, m_high, m_health, m_inv, m_frame;
    bit            m_tick, m_ps, m_pp;
    logic [NE-1:0] m_respawn;

    game_flow_ctrl #(
        .NUM_ENEMIES(NE), .SCORE_W(SW), .HEALTH_MAX(HM),
        .ENEMY_POINTS(PTS), .FRAME_DIV(FD), .INVULN_FRAMES(INV)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause),
        .enemy_hit(enemy_hit), .player_hit(player_hit),
        .state(state), .playing(playing), .game_end(game_end),
        .frame_tick(frame_tick), .score(score), .high_score(high_score),
        .health(health), .invuln(invuln), .enemy_respawn(enemy_respawn)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic model_edge(input bit s, input bit p, input logic [NE-1:0] eh,
                              input logic [NE-1:0] ph, input bit r);
        bit srise, prise;
        int nstate, kills, dmg_hits;
        logic [NE-1:0] nresp;
        bit ntick;
        if (!r) begin
            m_state = 0; m_score = 0; m_high = 0; m_health = 0; m_inv = 0;
            m_frame = 0; m_tick = 0; m_ps = 0; m_pp = 0; m_respawn = '0;
            return;
        end
        srise = s && !m_ps;
        prise = p && !m_pp;
        m_ps = s; m_pp = p;
        nstate = m_state; nresp = '0; ntick = 0;
        if (m_state == 0) begin
            if (srise) begin
                nstate = 1; m_health = HM; m_score = 0; m_inv = 0; m_frame = 0;
                nresp = '1;
            end
        end else if (m_state == 1) begin
            kills = 0; dmg_hits = 0;
            for (int i = 0; i < NE; i++) begin
                if (eh[i]) kills++;
                if (ph[i] && !eh[i]) dmg_hits++;
            end
            m_score = m_score + PTS * kills;
            if (m_score > (1 << SW) - 1) m_score = (1 << SW) - 1;
            nresp = eh | ph;
            if (dmg_hits > 0 && m_inv == 0) begin
                m_health = m_health - 1;
                m_inv = INV;
                if (m_health == 0) begin
                    nstate = 3;
                    if (m_score > m_high) m_high = m_score;
                end
            end else if (m_tick && m_inv > 0) begin
                m_inv = m_inv - 1;
            end
            if (nstate == 1 && prise) nstate = 2;
            if (nstate == 1) begin
                m_frame = (m_frame + 1) % FD;
                ntick = (m_frame == 0);
            end
        end else if (m_state == 2) begin
            if (prise) nstate = 1;
        end else begin
            if (srise) nstate = 0;
        end
        m_state = nstate; m_respawn = nresp; m_tick = ntick;
    endtask

    // Drive one cycle of inputs, update the model, and land #1 past the edge.
    task automatic step(input bit s, input bit p, input logic [NE-1:0] eh,
                        input logic [NE-1:0] ph, input bit r);
        start = s; pause = p; enemy_hit = eh; player_hit = ph; rst = r;
        model_edge(s, p, eh, ph, r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 1);
    endtask

    // Run idle cycles until invulnerability has expired (bounded).
    task automatic wait_invuln_clear();
        int k;
        k = 0;
        while (m_inv != 0 && k < 40) begin
            idle();
            k++;
        end
        n_checks++;
        if (invuln !== 1'b0 || m_inv != 0) begin
            n_fail++;
            $display("FAIL invuln_clear: invuln=%0b required 0 after %0d cycles", invuln, k);
        end
    endtask

    task automatic test_reset();
        step(0, 0, '0, '0, 0);
        step(0, 0, '0, '0, 0);
        n_checks++;
        if (state !== 2'd0 || score !== '0 || high_score !== '0 || health !== 2'd0 ||
            invuln !== 1'b0 || frame_tick !== 1'b0 || enemy_respawn !== '0 ||
            playing !== 1'b0 || game_end !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: state=%0d score=%0d high=%0d health=%0d inv=%0b tick=%0b resp=%b required all zero",
                     state, score, high_score, health, invuln, frame_tick, enemy_respawn);
        end
    endtask

    task automatic test_start();
        step(1, 0, '0, '0, 1);
        n_checks++;
        if (state !== 2'd1 || health !== 2'd3 || enemy_respawn !== 3'b111 || playing !== 1'b1) begin
            n_fail++;
            $display("FAIL start: state=%0d health=%0d resp=%b playing=%0b required 1/3/111/1",
                     state, health, enemy_respawn, playing);
        end
        for (int k = 1; k <= 8; k++) begin
            idle();
            if (k == 1) begin
                n_checks++;
                if (enemy_respawn !== 3'b000) begin
                    n_fail++;
                    $display("FAIL start_resp_pulse: resp=%b required 000", enemy_respawn);
                end
            end
            n_checks++;
            if (frame_tick !== ((k % FD) == 0)) begin
                n_fail++;
                $display("FAIL tick_period: cycle %0d tick=%0b required %0b", k, frame_tick, (k % FD) == 0);
            end
        end
    endtask

    task automatic test_kill();
        step(0, 0, 3'b101, 3'b000, 1);
        n_checks++;
        if (score !== 8'd20 || enemy_respawn !== 3'b101) begin
            n_fail++;
            $display("FAIL kill: score=%0d resp=%b required 20/101", score, enemy_respawn);
        end
    endtask

    task automatic test_same_index();
        step(0, 0, 3'b010, 3'b010, 1);
        n_checks++;
        if (score !== 8'd30 || health !== 2'd3 || enemy_respawn !== 3'b010 || invuln !== 1'b0) begin
            n_fail++;
            $display("FAIL same_index: score=%0d health=%0d resp=%b inv=%0b required 30/3/010/0",
                     score, health, enemy_respawn, invuln);
        end
    endtask

    task automatic test_damage();
        step(0, 0, 3'b000, 3'b011, 1);
        n_checks++;
        if (health !== 2'd2 || invuln !== 1'b1 || enemy_respawn !== 3'b011) begin
            n_fail++;
            $display("FAIL damage: health=%0d inv=%0b resp=%b required 2/1/011", health, invuln, enemy_respawn);
        end
        step(0, 0, 3'b000, 3'b001, 1);
        n_checks++;
        if (health !== 2'd2 || invuln !== 1'b1 || enemy_respawn !== 3'b001) begin
            n_fail++;
            $display("FAIL invuln_hit: health=%0d inv=%0b resp=%b required 2/1/001", health, invuln, enemy_respawn);
        end
        wait_invuln_clear();
    endtask

    task automatic test_pause();
        int k;
        k = 0;
        while (frame_tick !== 1'b1 && k < 10) begin
            idle();
            k++;
        end
        n_checks++;
        if (frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_sync: tick=%0b required 1 within 10 cycles", frame_tick);
        end
        idle();
        step(0, 1, '0, '0, 1);
        n_checks++;
        if (state !== 2'd2 || playing !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_enter: state=%0d playing=%0b required 2/0", state, playing);
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 3'b111, 3'b111, 1);
            n_checks++;
            if (state !== 2'd2 || frame_tick !== 1'b0 || score !== 8'd30 ||
                health !== 2'd2 || enemy_respawn !== 3'b000) begin
                n_fail++;
                $display("FAIL pause_hold: state=%0d tick=%0b score=%0d health=%0d resp=%b required 2/0/30/2/000",
                         state, frame_tick, score, health, enemy_respawn);
            end
        end
        step(0, 1, '0, '0, 1);
        n_checks++;
        if (state !== 2'd1 || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_exit: state=%0d tick=%0b required 1/0", state, frame_tick);
        end
        for (int i = 1; i <= 3; i++) begin
            idle();
            n_checks++;
            if (frame_tick !== (i == 3)) begin
                n_fail++;
                $display("FAIL resume_tick: cycle %0d tick=%0b required %0b", i, frame_tick, i == 3);
            end
        end
    endtask

    task automatic test_death_first();
        step(0, 0, 3'b000, 3'b100, 1);
        n_checks++;
        if (health !== 2'd1) begin
            n_fail++;
            $display("FAIL damage2: health=%0d required 1", health);
        end
        wait_invuln_clear();
        step(0, 0, 3'b000, 3'b001, 1);
        n_checks++;
        if (state !== 2'd3 || game_end !== 1'b1 || health !== 2'd0 || high_score !== 8'd30 || score !== 8'd30) begin
            n_fail++;
            $display("FAIL death1: state=%0d end=%0b health=%0d high=%0d score=%0d required 3/1/0/30/30",
                     state, game_end, health, high_score, score);
        end
        step(1, 0, '0, '0, 1);
        n_checks++;
        if (state !== 2'd0 || game_end !== 1'b0 || score !== 8'd30) begin
            n_fail++;
            $display("FAIL end_to_home: state=%0d end=%0b score=%0d required 0/0/30", state, game_end, score);
        end
    endtask

    task automatic test_death_high_score();
        idle();
        step(1, 0, '0, '0, 1);
        step(0, 0, 3'b111, 3'b000, 1);
        step(0, 0, 3'b001, 3'b000, 1);
        n_checks++;
        if (score !== 8'd40 || health !== 2'd3) begin
            n_fail++;
            $display("FAIL game2_score: score=%0d health=%0d required 40/3", score, health);
        end
        step(0, 0, 3'b000, 3'b010, 1);
        wait_invuln_clear();
        step(0, 0, 3'b000, 3'b010, 1);
        wait_invuln_clear();
        n_checks++;
        if (health !== 2'd1) begin
            n_fail++;
            $display("FAIL game2_health: health=%0d required 1", health);
        end
        // Fatal hit together with a pause rise: death takes priority.
        step(0, 1, 3'b000, 3'b100, 1);
        n_checks++;
        if (state !== 2'd3 || game_end !== 1'b1 || high_score !== 8'd40 || health !== 2'd0) begin
            n_fail++;
            $display("FAIL death2: state=%0d end=%0b high=%0d health=%0d required 3/1/40/0",
                     state, game_end, high_score, health);
        end
        idle();
        step(1, 0, '0, '0, 1);
        n_checks++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL home2: state=%0d required 0", state);
        end
    endtask

    task automatic test_saturate_and_reset();
        idle();
        step(1, 0, '0, '0, 1);
        for (int i = 0; i < 7; i++) step(0, 0, 3'b111, 3'b000, 1);
        step(0, 0, 3'b011, 3'b000, 1);
        step(0, 0, 3'b011, 3'b000, 1);
        n_checks++;
        if (score !== 8'd250) begin
            n_fail++;
            $display("FAIL score_250: score=%0d required 250", score);
        end
        step(0, 0, 3'b111, 3'b000, 1);
        n_checks++;
        if (score !== 8'd255 || enemy_respawn !== 3'b111) begin
            n_fail++;
            $display("FAIL saturate: score=%0d resp=%b required 255/111", score, enemy_respawn);
        end
        step(0, 0, 3'b010, 3'b100, 0);
        n_checks++;
        if (state !== 2'd0 || score !== '0 || high_score !== '0 || health !== 2'd0 ||
            invuln !== 1'b0 || frame_tick !== 1'b0 || enemy_respawn !== '0 || playing !== 1'b0) begin
            n_fail++;
            $display("FAIL midgame_reset: state=%0d score=%0d high=%0d health=%0d inv=%0b tick=%0b resp=%b required all zero",
                     state, score, high_score, health, invuln, frame_tick, enemy_respawn);
        end
    endtask

    task automatic test_random();
        bit s, p, r;
        logic [NE-1:0] eh, ph;
        s = 0; p = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) s = !s;
            if ($urandom_range(0, 9) == 0) p = !p;
            eh = ($urandom_range(0, 3) == 0) ? NE'($urandom_range(0, 7)) : '0;
            ph = ($urandom_range(0, 3) == 0) ? NE'($urandom_range(0, 7)) : '0;
            r  = ($urandom_range(0, 399) != 0);
            step(s, p, eh, ph, r);
            n_checks++;
            if (state !== 2'(m_state) || playing !== (m_state == 1) || game_end !== (m_state == 3)) begin
                n_fail++;
                $display("FAIL rand_state: cycle %0d state=%0d required %0d", c, state, m_state);
            end
            n_checks++;
            if (score !== SW'(m_score) || high_score !== SW'(m_high)) begin
                n_fail++;
                $display("FAIL rand_score: cycle %0d score=%0d high=%0d required %0d/%0d",
                         c, score, high_score, m_score, m_high);
            end
            n_checks++;
            if (health !== 2'(m_health) || invuln !== (m_inv != 0)) begin
                n_fail++;
                $display("FAIL rand_health: cycle %0d health=%0d inv=%0b required %0d/%0b",
                         c, health, invuln, m_health, m_inv != 0);
            end
            n_checks++;
            if (frame_tick !== m_tick || enemy_respawn !== m_respawn) begin
                n_fail++;
                $display("FAIL rand_tick_resp: cycle %0d tick=%0b resp=%b required %0b/%b",
                         c, frame_tick, enemy_respawn, m_tick, m_respawn);
            end
        end
    endtask

    initial begin
        m_state = 0; m_score = 0; m_high = 0; m_health = 0; m_inv = 0;
        m_frame = 0; m_tick = 0; m_ps = 0; m_pp = 0; m_respawn = '0;
        test_reset();
        test_start();
        test_kill();
        test_same_index();
        test_damage();
        test_pause();
        test_death_first();
        test_death_high_score();
        test_saturate_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised top-level game-flow controller that replaces the fixed three-state HOME/UPDATE/END sequencer in the game top level. It adds pause, a frame-tick generator, N-enemy hit bookkeeping, health with post-hit invulnerability, saturating score and a persistent high score. It sits between the collision/movement blocks, which produce hit pulses, and the VGA renderer, which reads state, score and health.

## Interface
Parameters:
- `NUM_ENEMIES`, default 3: number of enemy channels, ≥1.
- `SCORE_W`, default 16: score and high-score width.
- `HEALTH_MAX`, default 3: health loaded at game start, ≥1.
- `ENEMY_POINTS`, default 10: points per enemy kill.
- `FRAME_DIV`, default 833_333: clk cycles per frame tick (60 Hz at 50 MHz), ≥2.
- `INVULN_FRAMES`, default 60: frames of invulnerability after damage.

Ports (`HEALTH_W` = $clog2(HEALTH_MAX+1)):
- `clk` in 1: system clock, 50 MHz; the only clock.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: start button, level.
- `pause` in 1: pause button, level.
- `enemy_hit` in NUM_ENEMIES: bit i is a 1-cycle pulse when the player's projectile destroys enemy i.
- `player_hit` in NUM_ENEMIES: bit i is a 1-cycle pulse when enemy i reaches the player.
- `state` out 2: current state: HOME=0, PLAY=1, PAUSE=2, END=3.
- `playing` out 1: high when state==PLAY.
- `game_end` out 1: high when state==END.
- `frame_tick` out 1: 1-cycle pulse per frame, PLAY only.
- `score` out SCORE_W: current score.
- `high_score` out SCORE_W: best score since reset.
- `health` out HEALTH_W: remaining health.
- `invuln` out 1: high while invulnerable.
- `enemy_respawn` out NUM_ENEMIES: 1-cycle pulse telling enemy i's movement block to restart.

## Operation
- `start` and `pause` are edge-detected internally using registered copies. Only rising edges act. The registers clear on reset, so an input already high at reset release does not count as an edge.
- HOME: on a `start` rise, go to PLAY. In the same edge:
  - load `health`=HEALTH_MAX, `score`=0, invulnerability counter=0;
  - drive `enemy_respawn`=all ones for one cycle.
- PLAY:
  - a `pause` rise goes to PAUSE;
  - the frame counter runs;
  - hit inputs are processed.
- PAUSE:
  - a `pause` rise returns to PLAY;
  - the frame counter holds its value, with no tick;
  - the invulnerability counter holds;
  - hit inputs are ignored.
- END: on a `start` rise, go to HOME. `score` holds until the next game starts.
- `enemy_hit` and `player_hit` are ignored in HOME, PAUSE and END.
- Kill, PLAY only:
  - `score` += ENEMY_POINTS × popcount(`enemy_hit`), saturating at 2^SCORE_W−1;
  - `enemy_respawn`[i] pulses for each set bit.
- Damage, PLAY only. Let eff = `player_hit` & ~`enemy_hit`; on the same index the kill wins and there is no damage.
  - Any bit of eff causes `enemy_respawn`[i] to pulse.
  - If eff≠0 and the invulnerability counter is 0: `health` −= 1, once regardless of the popcount, and the counter loads INVULN_FRAMES.
  - If the counter is nonzero: respawn only, no damage.
- Invulnerability counter decrements on each `frame_tick` while nonzero. `invuln` = (counter≠0).
- Death: a damage event with `health`==1 sets `health`=0 and moves to END on the same edge.
  - Kills in that same cycle are still scored.
  - On that edge, `high_score` loads max(`high_score`, final score).
- A simultaneous `pause` rise and fatal hit: death wins, next state END.
- A simultaneous `start` rise in any state other than HOME and END: ignored.

## Timing
- All outputs are registered. An input event at edge t is visible after edge t, with latency 1 cycle.
- `frame_tick` is high for exactly one cycle when the counter wraps from FRAME_DIV−1 to 0.
  - The counter clears to 0 on entry to PLAY from HOME.
  - On PAUSE→PLAY it resumes from its held value.
- `enemy_respawn` is high for exactly one cycle per event. It is 0 in every other cycle.
- Reset, valid mid-game, takes effect at the next clk edge:
  - `state`=HOME;
  - `score`=`high_score`=`health`=0;
  - `invuln`=`frame_tick`=0;
  - `enemy_respawn`=0;
  - frame and invulnerability counters = 0.

## Structure
- Shared package `game_pkg`: state encoding constants (HOME/PLAY/PAUSE/END, 2-bit), default ENEMY_POINTS, and a popcount function for the hit vectors.
- One sub-module: `frame_tick_gen`.
  - Parameter FRAME_DIV.
  - Inputs `clk`, `rst`, `run` (state==PLAY), `clear` (HOME→PLAY).
  - Output `tick`.
- Everything else stays inline in `game_flow_ctrl`.

## Test plan
Use NUM_ENEMIES=3, FRAME_DIV=4, INVULN_FRAMES=2 and SCORE_W=8 unless stated.

- Reset then `start` rise → `state`=1 and `health`=3 next cycle, `enemy_respawn`=3'b111 for one cycle, and `frame_tick` every 4th cycle.
- `enemy_hit`=3'b101 in PLAY → `score`=20 and `enemy_respawn`=3'b101 next cycle. With `score`=250, `enemy_hit`=3'b111 → `score`=255 (saturated).
- `player_hit`=3'b011 → `health` 3→2 (a single decrement), `invuln`=1, `enemy_respawn`=3'b011. A second hit before 2 ticks → no damage, respawn only. After 2 ticks `invuln`=0.
- `enemy_hit`=`player_hit`=3'b010 in the same cycle → `score`+10, `health` unchanged, `enemy_respawn`=3'b010.
- `pause` rise mid-frame → `state`=2, no ticks, hits ignored. Second `pause` rise → PLAY, with the next tick arriving after the remaining frame cycles.
- Fatal hit with `health`=1 and score 40, previous `high_score` 30 → `state`=3, `game_end`=1, `high_score`=40. `start` rise → HOME. Mid-PLAY `rst`=0 → all outputs at reset values next edge.
